// File: rtl/rom_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module   : rom_sweep_checker
// Purpose  : Self-checking read sweeper for single-port ROMs. A start pulse
//            issues one read per cycle over addresses 0..ADDR_LAST. Returned
//            data is aligned to RD_LATENCY and compared against an expected
//            value: a constant, or the address XOR a mask. The block reports
//            pass/fail, a saturating error count and the first failing
//            address and data.
// Ports    : clk, tb_rst (async, active-high)
//            start          - one-cycle pulse, begins a sweep when idle
//            stall          - suppresses new reads while high (SWEEP only)
//            rom_addr       - ROM address (issue counter)
//            rom_rd_en      - ROM read enable
//            rom_rd_data    - ROM read data, valid RD_LATENCY cycles after
//                             the read is issued
//            busy           - sweep or drain in progress
//            done           - one-cycle pulse at sweep completion
//            pass           - result of the last completed sweep
//            err_cnt        - mismatch count, saturating
//            first_err_addr - address of the first mismatch
//            first_err_data - data read at the first mismatch
// Options  : `define ROM_SWEEP_STOP_ON_ERR_EN to end the sweep at the first
//            mismatch. Reads already issued then drain without being counted.
// Revision : 1.0 - initial release
// ============================================================================
module rom_sweep_checker #(
    parameter int                    ADDR_WIDTH    = 16,
    parameter int                    DATA_WIDTH    = 24,
    parameter int                    RD_LATENCY    = 1,
    parameter int unsigned           ADDR_LAST     = (1 << ADDR_WIDTH) - 1,
    parameter int                    EXPECT_MODE   = 0,
    parameter logic [DATA_WIDTH-1:0] EXPECT_CONST  = {DATA_WIDTH{1'b1}},
    parameter int                    ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     tb_rst,
    input  logic                     start,
    input  logic                     stall,
    output logic [ADDR_WIDTH-1:0]    rom_addr,
    output logic                     rom_rd_en,
    input  logic [DATA_WIDTH-1:0]    rom_rd_data,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt,
    output logic [ADDR_WIDTH-1:0]    first_err_addr,
    output logic [DATA_WIDTH-1:0]    first_err_data
);

    localparam logic [ADDR_WIDTH-1:0] c_addr_last = ADDR_WIDTH'(ADDR_LAST);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                              r_state;
    state_t                              w_state_nxt;

    logic [ADDR_WIDTH-1:0]               r_addr_cnt;
    logic [RD_LATENCY-1:0]               r_pipe_vld;
    logic [RD_LATENCY-1:0][ADDR_WIDTH-1:0] r_pipe_addr;

    logic [ERR_CNT_WIDTH-1:0]            r_err_cnt;
    logic [ADDR_WIDTH-1:0]               r_first_addr;
    logic [DATA_WIDTH-1:0]               r_first_data;
    logic                                r_pass;

    logic                                w_tail_vld;
    logic [ADDR_WIDTH-1:0]               w_tail_addr;
    logic [DATA_WIDTH-1:0]               w_expected;
    logic                                w_check;
    logic                                w_err_inc;
    logic                                w_last_issue;

    // ------------------------------------------------------------------------
    // Read issue: combinational so a stall takes effect in the same cycle.
    // ------------------------------------------------------------------------
    assign rom_rd_en = (r_state == ST_SWEEP) && !stall;
    assign rom_addr  = r_addr_cnt;
    // The end of the range is detected by equality so that a full
    // 2**ADDR_WIDTH sweep terminates without relying on counter wrap.
    assign w_last_issue = rom_rd_en && (r_addr_cnt == c_addr_last);

    // ------------------------------------------------------------------------
    // Check pipeline: {valid, addr} follows each read by RD_LATENCY cycles so
    // the tail entry lines up with rom_rd_data.
    // ------------------------------------------------------------------------
    generate
        if (RD_LATENCY == 1) begin : g_pipe_one
            always_ff @(posedge clk or posedge tb_rst) begin
                if (tb_rst) begin
                    r_pipe_vld  <= '0;
                    r_pipe_addr <= '0;
                end else begin
                    r_pipe_vld[0]  <= rom_rd_en;
                    r_pipe_addr[0] <= rom_addr;
                end
            end
        end else begin : g_pipe_multi
            always_ff @(posedge clk or posedge tb_rst) begin
                if (tb_rst) begin
                    r_pipe_vld  <= '0;
                    r_pipe_addr <= '0;
                end else begin
                    r_pipe_vld  <= {r_pipe_vld[RD_LATENCY-2:0], rom_rd_en};
                    r_pipe_addr <= {r_pipe_addr[RD_LATENCY-2:0], rom_addr};
                end
            end
        end
    endgenerate

    assign w_tail_vld  = r_pipe_vld[RD_LATENCY-1];
    assign w_tail_addr = r_pipe_addr[RD_LATENCY-1];

    // ------------------------------------------------------------------------
    // Expected value for the tail address.
    // ------------------------------------------------------------------------
    generate
        if (EXPECT_MODE == 1) begin : g_exp_addr
            logic [DATA_WIDTH-1:0] w_addr_ext;
            if (DATA_WIDTH > ADDR_WIDTH) begin : g_ext_zero
                assign w_addr_ext = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, w_tail_addr};
            end else if (DATA_WIDTH == ADDR_WIDTH) begin : g_ext_same
                assign w_addr_ext = w_tail_addr;
            end else begin : g_ext_trunc
                assign w_addr_ext = w_tail_addr[DATA_WIDTH-1:0];
            end
            assign w_expected = w_addr_ext ^ EXPECT_CONST;
        end else begin : g_exp_const
            assign w_expected = EXPECT_CONST;
        end
    endgenerate

`ifdef ROM_SWEEP_STOP_ON_ERR_EN
    // Set by the first mismatch; reads still in flight are then ignored.
    logic r_stopped;

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            r_stopped <= 1'b0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_stopped <= 1'b0;
        end else if (w_err_inc) begin
            r_stopped <= 1'b1;
        end
    end

    assign w_check = w_tail_vld && !r_stopped;
`else
    assign w_check = w_tail_vld;
`endif

    assign w_err_inc = w_check && (rom_rd_data != w_expected);

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                if (w_last_issue) begin
                    w_state_nxt = ST_DRAIN;
                end
`ifdef ROM_SWEEP_STOP_ON_ERR_EN
                if (w_err_inc) begin
                    w_state_nxt = ST_DRAIN;
                end
`endif
            end
            ST_DRAIN: begin
                // Leave only once every issued read has been retired.
                if (r_pipe_vld == '0) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Issue counter and result registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            r_addr_cnt   <= '0;
            r_err_cnt    <= '0;
            r_first_addr <= '0;
            r_first_data <= '0;
            r_pass       <= 1'b0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_addr_cnt   <= '0;
            r_err_cnt    <= '0;
            r_first_addr <= '0;
            r_first_data <= '0;
            r_pass       <= 1'b0;
        end else begin
            // The counter parks on the last address rather than wrapping.
            if (rom_rd_en && !w_last_issue) begin
                r_addr_cnt <= r_addr_cnt + 1'b1;
            end
            if (w_err_inc) begin
                if (r_err_cnt != '1) begin
                    r_err_cnt <= r_err_cnt + 1'b1;
                end
                if (r_err_cnt == '0) begin
                    r_first_addr <= w_tail_addr;
                    r_first_data <= rom_rd_data;
                end
            end
            // Result becomes visible together with the done pulse.
            if ((r_state == ST_DRAIN) && (w_state_nxt == ST_DONE)) begin
                r_pass <= (r_err_cnt == '0) && !w_err_inc;
            end
        end
    end

    assign busy           = (r_state == ST_SWEEP) || (r_state == ST_DRAIN);
    assign done           = (r_state == ST_DONE);
    assign pass           = r_pass;
    assign err_cnt        = r_err_cnt;
    assign first_err_addr = r_first_addr;
    assign first_err_data = r_first_data;

endmodule
`default_nettype wire

// File: tb/tb_rom_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_sweep_checker
// Purpose  : Directed self-checking bench for rom_sweep_checker. Three
//            instances cover constant/address expectation, read latency 1
//            and 3, and a narrow saturating error counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rom_sweep_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic tb_rst;
    logic start_r;
    logic stall_r;
    int   sel;

    logic [23:0] rom_a [16];
    logic [23:0] rom_b [16];
    logic [23:0] rom_c [16];

    // Instance A: latency 1, constant expectation
    logic        start_a, stall_a, rd_a, busy_a, done_a, pass_a;
    logic [3:0]  addr_a, fea_a;
    logic [23:0] rdat_a, fed_a;
    logic [7:0]  err_a;
    // Instance B: latency 3, address expectation
    logic        start_b, stall_b, rd_b, busy_b, done_b, pass_b;
    logic [3:0]  addr_b, fea_b;
    logic [23:0] rdat_b, fed_b, rb_q1, rb_q2;
    logic [7:0]  err_b;
    // Instance C: 3-bit error counter
    logic        start_c, stall_c, rd_c, busy_c, done_c, pass_c;
    logic [3:0]  addr_c, fea_c;
    logic [23:0] rdat_c, fed_c;
    logic [2:0]  err_c;

    assign start_a = start_r & (sel == 0);
    assign start_b = start_r & (sel == 1);
    assign start_c = start_r & (sel == 2);
    assign stall_a = stall_r & (sel == 0);
    assign stall_b = stall_r & (sel == 1);
    assign stall_c = stall_r & (sel == 2);

    rom_sweep_checker #(
        .ADDR_WIDTH(4), .DATA_WIDTH(24), .RD_LATENCY(1), .EXPECT_MODE(0),
        .EXPECT_CONST(24'hFFFFFF), .ERR_CNT_WIDTH(8)
    ) u_dut_a (
        .clk(clk), .tb_rst(tb_rst), .start(start_a), .stall(stall_a),
        .rom_addr(addr_a), .rom_rd_en(rd_a), .rom_rd_data(rdat_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a),
        .first_err_addr(fea_a), .first_err_data(fed_a)
    );

    rom_sweep_checker #(
        .ADDR_WIDTH(4), .DATA_WIDTH(24), .RD_LATENCY(3), .EXPECT_MODE(1),
        .EXPECT_CONST(24'h000000), .ERR_CNT_WIDTH(8)
    ) u_dut_b (
        .clk(clk), .tb_rst(tb_rst), .start(start_b), .stall(stall_b),
        .rom_addr(addr_b), .rom_rd_en(rd_b), .rom_rd_data(rdat_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b),
        .first_err_addr(fea_b), .first_err_data(fed_b)
    );

    rom_sweep_checker #(
        .ADDR_WIDTH(4), .DATA_WIDTH(24), .RD_LATENCY(1), .EXPECT_MODE(0),
        .EXPECT_CONST(24'hFFFFFF), .ERR_CNT_WIDTH(3)
    ) u_dut_c (
        .clk(clk), .tb_rst(tb_rst), .start(start_c), .stall(stall_c),
        .rom_addr(addr_c), .rom_rd_en(rd_c), .rom_rd_data(rdat_c),
        .busy(busy_c), .done(done_c), .pass(pass_c), .err_cnt(err_c),
        .first_err_addr(fea_c), .first_err_data(fed_c)
    );

    // ROM models: synchronous read, registered 1 or 3 deep
    always_ff @(posedge clk) begin
        rdat_a <= rom_a[addr_a];
        rdat_c <= rom_c[addr_c];
        rb_q1  <= rom_b[addr_b];
        rb_q2  <= rb_q1;
        rdat_b <= rb_q2;
    end

    // Observation mux for the selected instance
    logic        m_rd, m_busy, m_done, m_pass;
    logic [3:0]  m_addr, m_fea;
    logic [23:0] m_fed;
    logic [7:0]  m_err;

    always_comb begin
        m_rd = rd_a; m_busy = busy_a; m_done = done_a; m_pass = pass_a;
        m_addr = addr_a; m_fea = fea_a; m_fed = fed_a; m_err = err_a;
        case (sel)
            1: begin
                m_rd = rd_b; m_busy = busy_b; m_done = done_b; m_pass = pass_b;
                m_addr = addr_b; m_fea = fea_b; m_fed = fed_b; m_err = err_b;
            end
            2: begin
                m_rd = rd_c; m_busy = busy_c; m_done = done_c; m_pass = pass_c;
                m_addr = addr_c; m_fea = fea_c; m_fed = fed_c; m_err = {5'd0, err_c};
            end
            default: begin
            end
        endcase
    end

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    int res_done_cyc, res_reads, res_last_addr, res_last_issue, res_order;
    int res_stall_errs, res_stall_addr, res_err_cyc;
    int res_busy0, res_busy1, res_pass, res_err, res_fea, res_fed;
    int res_pass_hold, res_done_hold;

    // Start a sweep on instance `which` at cycle 0 and follow it to done.
    task automatic run_sweep(input int which, input int stall_at, input int stall_len,
                             input int restart_at);
        int exp_addr;
        bit seen;
        sel = which;
        exp_addr = 0; seen = 1'b0;
        res_done_cyc = -1; res_reads = 0; res_last_addr = -1; res_last_issue = -1;
        res_order = 0; res_stall_errs = 0; res_stall_addr = -1; res_err_cyc = -1;
        @(negedge clk);
        start_r = 1'b1;
        #1;
        res_busy0 = int'(m_busy);
        for (int n = 1; n <= 300 && !seen; n++) begin
            @(negedge clk);
            start_r = (n == restart_at);
            stall_r = (n >= stall_at) && (n < stall_at + stall_len);
            #1;
            if (n == 1) res_busy1 = int'(m_busy);
            if (stall_r) begin
                if (n == stall_at) res_stall_addr = int'(m_addr);
                else if (int'(m_addr) != res_stall_addr) res_stall_errs++;
                if (m_rd) res_stall_errs++;
            end
            if (m_rd) begin
                if (int'(m_addr) != exp_addr) res_order++;
                exp_addr++;
                res_reads++;
                res_last_addr = int'(m_addr);
                res_last_issue = n;
            end
            if (m_err != 8'd0 && res_err_cyc < 0) res_err_cyc = n;
            if (m_done) begin
                seen = 1'b1;
                res_done_cyc = n;
                res_pass = int'(m_pass);
                res_err  = int'(m_err);
                res_fea  = int'(m_fea);
                res_fed  = int'(m_fed);
            end
        end
        start_r = 1'b0;
        stall_r = 1'b0;
        check_eq("done_seen", 32'(seen), 32'd1);
        @(negedge clk);
        #1;
        res_pass_hold = int'(m_pass);
        res_done_hold = int'(m_done);
    endtask

    initial begin
        tb_rst = 1'b1; start_r = 1'b0; stall_r = 1'b0; sel = 0;
        for (int i = 0; i < 16; i++) begin
            rom_a[i] = 24'hFFFFFF;
            rom_b[i] = 24'(i);
            rom_c[i] = 24'h000000;
        end
        repeat (3) @(negedge clk);
        #1;
        // Reset state
        check_eq("rst_rom_addr", 32'(addr_a), 32'd0);
        check_eq("rst_rd_en",    32'(rd_a),   32'd0);
        check_eq("rst_busy",     32'(busy_a), 32'd0);
        check_eq("rst_done",     32'(done_a), 32'd0);
        check_eq("rst_pass",     32'(pass_a), 32'd0);
        check_eq("rst_err_cnt",  32'(err_a),  32'd0);
        check_eq("rst_fea",      32'(fea_a),  32'd0);
        check_eq("rst_fed",      32'(fed_a),  32'd0);
        tb_rst = 1'b0;
        repeat (2) @(negedge clk);

        // Clean sweep, latency 1
        run_sweep(0, 0, 0, 0);
        check_eq("a_clean_busy_c0",  res_busy0, 0);
        check_eq("a_clean_busy_c1",  res_busy1, 1);
        check_eq("a_clean_done_cyc", res_done_cyc, 19);
        check_eq("a_clean_reads",    res_reads, 16);
        check_eq("a_clean_last",     res_last_addr, 15);
        check_eq("a_clean_order",    res_order, 0);
        check_eq("a_clean_pass",     res_pass, 1);
        check_eq("a_clean_err",      res_err, 0);
        check_eq("a_clean_pass_hold", res_pass_hold, 1);
        check_eq("a_clean_done_hold", res_done_hold, 0);

        // Two bad words
        rom_a[5] = 24'h000000;
        rom_a[9] = 24'h123456;
        run_sweep(0, 0, 0, 0);
        check_eq("a_bad_pass",    res_pass, 0);
        check_eq("a_bad_err",     res_err, 2);
        check_eq("a_bad_fea",     res_fea, 5);
        check_eq("a_bad_fed",     res_fed, 0);
        check_eq("a_bad_err_cyc", res_err_cyc, 8);
        check_eq("a_bad_done",    res_done_cyc, 19);
        check_eq("a_bad_err_hold", 32'(err_a), 32'd2);
        rom_a[5] = 24'hFFFFFF;
        rom_a[9] = 24'hFFFFFF;

        // Latency 3, address expectation
        run_sweep(1, 0, 0, 0);
        check_eq("b_clean_pass", res_pass, 1);
        check_eq("b_clean_err",  res_err, 0);
        check_eq("b_clean_done", res_done_cyc, 21);
        rom_b[15] = 24'hABCDEF;
        run_sweep(1, 0, 0, 0);
        check_eq("b_bad_pass",       res_pass, 0);
        check_eq("b_bad_err",        res_err, 1);
        check_eq("b_bad_fea",        res_fea, 15);
        check_eq("b_bad_fed",        res_fed, 32'hABCDEF);
        check_eq("b_bad_last_issue", res_last_issue, 16);
        check_eq("b_bad_err_cyc",    res_err_cyc, 20);

        // All words wrong, 3-bit counter saturates
        run_sweep(2, 0, 0, 0);
        check_eq("c_sat_err",  res_err, 7);
        check_eq("c_sat_pass", res_pass, 0);
        check_eq("c_sat_done", res_done_cyc, 19);

        // Stall cycles 6..9 plus an ignored start at cycle 3
        run_sweep(0, 6, 4, 3);
        check_eq("stall_done_cyc",  res_done_cyc, 23);
        check_eq("stall_reads",     res_reads, 16);
        check_eq("stall_order",     res_order, 0);
        check_eq("stall_held_addr", res_stall_addr, 5);
        check_eq("stall_errs",      res_stall_errs, 0);
        check_eq("stall_pass",      res_pass, 1);
        check_eq("stall_fea_clr",   res_fea, 0);

        // Asynchronous reset mid-sweep
        rom_a[2] = 24'h00AA55;
        sel = 0;
        @(negedge clk); start_r = 1'b1;
        @(negedge clk); start_r = 1'b0;
        repeat (7) @(negedge clk);
        #1;
        check_eq("pre_rst_err",  32'(err_a),  32'd1);
        check_eq("pre_rst_addr", 32'(addr_a), 32'd7);
        tb_rst = 1'b1;
        #1;
        check_eq("mid_rst_rd_en", 32'(rd_a),   32'd0);
        check_eq("mid_rst_addr",  32'(addr_a), 32'd0);
        check_eq("mid_rst_busy",  32'(busy_a), 32'd0);
        check_eq("mid_rst_err",   32'(err_a),  32'd0);
        check_eq("mid_rst_fea",   32'(fea_a),  32'd0);
        check_eq("mid_rst_fed",   32'(fed_a),  32'd0);
        @(negedge clk);
        tb_rst = 1'b0;
        rom_a[2] = 24'hFFFFFF;
        @(negedge clk);
        run_sweep(0, 0, 0, 0);
        check_eq("post_rst_done", res_done_cyc, 19);
        check_eq("post_rst_pass", res_pass, 1);

        // Single bad word at address 3
        rom_a[3] = 24'h000000;
        run_sweep(0, 0, 0, 0);
        check_eq("stop_err",  res_err, 1);
        check_eq("stop_pass", res_pass, 0);
        check_eq("stop_fea",  res_fea, 3);
`ifdef ROM_SWEEP_STOP_ON_ERR_EN
        check_eq("stop_last",  res_last_addr, 4);
        check_eq("stop_reads", res_reads, 5);
        check_eq("stop_done",  res_done_cyc, 8);
`else
        check_eq("stop_last",  res_last_addr, 15);
        check_eq("stop_reads", res_reads, 16);
        check_eq("stop_done",  res_done_cyc, 19);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rom_sweep_checker.md
Name: rom_sweep_checker

Overview:
Synthesizable self-checking sweeper for single-port ROMs, such as image/coefficient ROMs in the HDMI picture filter demos. On a start pulse it issues one read per cycle over an address range and aligns returned data to a configurable read latency. It compares each word against an expected value and reports pass/fail, an error count and the first failing address/data. It is used both on-board (built-in self-test) and inside benches.

Parameters:
ADDR_WIDTH, 16, ROM address width (9..20)
DATA_WIDTH, 24, ROM data width (1..1152)
RD_LATENCY, 1, cycles from rd_en/addr to valid rd_data (1..3; 2 = output register, 3 = output register + OCE stage)
ADDR_LAST, 2**ADDR_WIDTH-1, last address swept; first address is always 0
EXPECT_MODE, 0, 0 = expected is EXPECT_CONST; 1 = expected is zero-extended/truncated address XOR EXPECT_CONST
EXPECT_CONST, {DATA_WIDTH{1'b1}}, expected constant / XOR mask
ERR_CNT_WIDTH, 8, error counter width

Ports:
clk  in  1  clock
tb_rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle pulse; begins a sweep when idle
stall  in  1  suppresses issuing new reads while high
rom_addr  out  ADDR_WIDTH  ROM address
rom_rd_en  out  1  ROM read enable
rom_rd_data  in  DATA_WIDTH  ROM read data
busy  out  1  sweep or drain in progress
done  out  1  one-cycle pulse at sweep completion
pass  out  1  result of last completed sweep
err_cnt  out  ERR_CNT_WIDTH  mismatch count, saturating
first_err_addr  out  ADDR_WIDTH  address of first mismatch
first_err_data  out  DATA_WIDTH  data read at first mismatch

Behaviour:
- Reset clk and tb_rst: tb_rst is asynchronous and active-high; clock is clk.
- Reset values: rom_addr=0, rom_rd_en=0, busy=0, done=0, pass=0, err_cnt=0, first_err_addr=0, first_err_data=0. FSM resets to IDLE and the latency pipeline clears.
- FSM states: IDLE, SWEEP, DRAIN, DONE.
- IDLE:
  - start=1 clears err_cnt, first_err_*, pass and the issue address counter, then moves to SWEEP.
  - busy goes high the cycle after start.
- SWEEP:
  - Each cycle with stall=0: rom_rd_en=1, rom_addr=issue counter, counter increments.
  - stall=1: rom_rd_en=0, rom_addr holds, pipeline keeps advancing.
  - After issuing ADDR_LAST, moves to DRAIN. rom_rd_en is 0 from then on.
- Check pipeline:
  - RD_LATENCY-deep shift register of {valid, addr}, loaded from {rom_rd_en, rom_addr}.
  - When the tail entry is valid, rom_rd_data is compared to the expected value for the tail addr.
  - Mismatch: err_cnt+1, saturating at all-ones.
  - On the first mismatch only (err_cnt==0): capture first_err_addr and first_err_data.
- DRAIN: waits until the pipeline holds no valid entries (exactly RD_LATENCY cycles after the last issue), then moves to DONE.
- DONE: one cycle; done=1, pass=(err_cnt==0 including any mismatch checked that cycle), busy=0 → IDLE. pass and err_cnt hold until the next start.
- start while busy: ignored.
- stall outside SWEEP: no effect.
- ADDR_LAST=2**ADDR_WIDTH-1: the issue counter must not wrap before termination. The last-address test uses equality, not overflow.
- Sweep length with no stalls: start at cycle 0 → done at cycle ADDR_LAST+1+RD_LATENCY+2.
- tb_rst mid-sweep: immediate return to reset values; any in-flight reads are discarded.

Optional Feature:
ROM_SWEEP_STOP_ON_ERR_EN
- Defined:
  - The first mismatch forces SWEEP→DRAIN on the next cycle; no further reads are issued.
  - Already-issued reads drain but are not counted.
  - done pulses with pass=0 and err_cnt=1.
- Undefined: the full range is always swept and all mismatches are counted.

Test Plan:
- ADDR_WIDTH=4, RD_LATENCY=1, EXPECT_MODE=0, ROM all 0xFFFFFF, start pulse → 16 reads on addr 0..15, done at cycle 19, pass=1, err_cnt=0.
- Same setup, ROM[5]=0x000000 and ROM[9]=0x123456 → pass=0, err_cnt=2, first_err_addr=5, first_err_data=0x000000.
- RD_LATENCY=3, EXPECT_MODE=1, EXPECT_CONST=0, ROM[a]=a → pass=1. Then corrupt ROM[15] → first_err_addr=15, checked exactly 3 cycles after issue.
- ERR_CNT_WIDTH=3, all 16 words wrong → err_cnt saturates at 7, pass=0.
- stall high for 4 cycles mid-sweep, plus a second start while busy → rom_rd_en=0 and addr held during the stall, done delayed by 4 cycles, second start ignored. tb_rst asserted mid-sweep → all outputs return to 0 immediately.
- With ROM_SWEEP_STOP_ON_ERR_EN, ROM[3] bad → last issued address 4 (RD_LATENCY=1), done pulse, err_cnt=1, pass=0.
